// File: rtl/adbg_crc_ctrl.sv
// -----------------------------------------------------------------------------
// adbg_crc_ctrl
//
// Frame sequencer for an external serial CRC32 engine. A frame is requested
// with start in IDLE, which latches mode and len. The engine is cleared, the
// len payload bits are streamed into it LSB-first, and then the 32 CRC
// register bits are shifted out of it:
//   - generate mode (mode=0): CRC bits go out on tx_bit/tx_valid/tx_ready.
//   - check mode    (mode=1): received CRC bits arrive on bit_in/bit_valid and
//                             are compared with the engine's bit 0.
// A one-cycle done pulse ends the frame, and crc_ok reports the result.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   start, mode, len             frame request, mode and payload bit count
//   bit_in, bit_valid, bit_ready inbound serial bit handshake
//   tx_bit, tx_valid, tx_ready   outbound CRC bit handshake
//   busy, done, crc_ok           frame status
//   crc_clr, crc_en, crc_data,   CRC engine controls: clear, LSB-first update,
//   crc_shift                    update data bit, shift right
//   crc_serial                   CRC engine register bit 0
// -----------------------------------------------------------------------------
module adbg_crc_ctrl #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic                 tx_bit,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic                 crc_clr,
    output logic                 crc_en,
    output logic                 crc_data,
    output logic                 crc_shift,
    input  logic                 crc_serial
);

    // The counter must hold both any payload length and the CRC bit count 32.
    localparam int CNT_W = (LEN_WIDTH > 6) ? LEN_WIDTH : 6;

    localparam logic [CNT_W-1:0] CNT_CRC_BITS = CNT_W'(32);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_DATA  = 3'd2,
        S_CRC   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mismatch_q, mismatch_d;
    logic                 crc_ok_q, crc_ok_d;

    // Engine strobes and handshake outputs, decoded from state and handshake inputs.
    always_comb begin
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        crc_data  = 1'b0;
        crc_shift = 1'b0;
        bit_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_bit    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                crc_clr = 1'b1;
            end
            S_DATA: begin
                bit_ready = 1'b1;
                if (bit_valid) begin
                    crc_en   = 1'b1;
                    crc_data = bit_in;
                end else begin
                    crc_en   = 1'b0;
                end
            end
            S_CRC: begin
                if (!mode_q) begin
                    tx_valid  = 1'b1;
                    tx_bit    = crc_serial;
                    crc_shift = tx_ready;
                end else begin
                    bit_ready = 1'b1;
                    crc_shift = bit_valid;
                end
            end
            default: begin
                crc_clr = 1'b0;
            end
        endcase
    end

    // Next-state, counter and result computation.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        mismatch_d = mismatch_q;
        crc_ok_d   = crc_ok_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = len;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                crc_ok_d   = 1'b0;
                mismatch_d = 1'b0;
                if (len_q != '0) begin
                    cnt_d   = CNT_W'(len_q);
                    state_d = S_DATA;
                end else begin
                    cnt_d   = CNT_CRC_BITS;
                    state_d = S_CRC;
                end
            end
            S_DATA: begin
                if (bit_valid) begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d   = CNT_CRC_BITS;
                        state_d = S_CRC;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_CRC: begin
                // One CRC bit moves per accepted handshake on the mode's side.
                if (mode_q ? bit_valid : tx_ready) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (mode_q && (bit_in != crc_serial)) begin
                        mismatch_d = 1'b1;
                    end else begin
                        mismatch_d = mismatch_q;
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                        // Result is settled on entry to DONE so it is valid with the pulse.
                        crc_ok_d = mode_q ? !(mismatch_q | (bit_in ^ crc_serial)) : 1'b1;
                    end else begin
                        state_d = S_CRC;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DONE: begin
                cnt_d   = CNT_ZERO;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= CNT_ZERO;
            mismatch_q <= 1'b0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign crc_ok = crc_ok_q;

endmodule

// File: tb/tb_adbg_crc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adbg_crc_ctrl
//
// Self-checking bench for adbg_crc_ctrl. A behavioural CRC32 engine sits on the
// engine ports; expected CRC bits come from a reference CRC computed over the
// payload bit list. Frames use random payloads and random handshake stalls.
// -----------------------------------------------------------------------------
module tb_adbg_crc_ctrl;

    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [LW-1:0] len;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic          tx_bit;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic          crc_clr;
    logic          crc_en;
    logic          crc_data;
    logic          crc_shift;
    logic          crc_serial;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] eng_q = 32'h0;

    adbg_crc_ctrl #(.LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .crc_ok     (crc_ok),
        .crc_clr    (crc_clr),
        .crc_en     (crc_en),
        .crc_data   (crc_data),
        .crc_shift  (crc_shift),
        .crc_serial (crc_serial)
    );

    always #5 clk = ~clk;

    // External CRC32 engine: reflected polynomial, LSB-first update, shift right.
    always @(posedge clk) begin
        if (crc_clr) begin
            eng_q <= 32'hFFFF_FFFF;
        end else if (crc_en) begin
            eng_q <= (eng_q >> 1) ^ (((eng_q[0] ^ crc_data) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
        end else if (crc_shift) begin
            eng_q <= eng_q >> 1;
        end
    end
    assign crc_serial = eng_q[0];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] all_outs();
        return {busy, done, crc_ok, bit_ready, tx_valid, tx_bit, crc_clr, crc_en, crc_data, crc_shift};
    endfunction

    // Reference CRC32 over a bit list, initial value all ones, no final inversion.
    function automatic logic [31:0] ref_crc(input bit bits[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (bits[i]) begin
            if ((c[0] ^ bits[i]) != 1'b0) c = (c >> 1) ^ 32'hEDB8_8320;
            else                          c = c >> 1;
        end
        return c;
    endfunction

    // Runs one frame. pattern>=0 gives payload bits from its LSBs, else random.
    // flip>=0 inverts that received CRC bit in check mode. exp_lat<0 skips the
    // latency check; abort_at>=0 asserts rst during that cycle of the frame.
    task automatic run_frame(input string tag, input bit m, input int n, input int pattern,
                             input int flip, input int pv, input int pr, input bit spam,
                             input int exp_lat, input int abort_at);
        bit          data[$];
        bit          stream[$];
        bit          got_tx[$];
        logic [31:0] exp_crc;
        logic [31:0] got_word;
        int          ptr, cyc, budget, post, done_cyc, done_cnt;
        int          clr_cnt, clr_cyc, en_cnt, txv_cnt, bad;
        bit          done_seen, acc, exp_en, exp_shift, ok_after;
        data.delete(); stream.delete(); got_tx.delete();
        for (int i = 0; i < n; i++) begin
            if (pattern >= 0) data.push_back(((pattern >> i) & 1) != 0);
            else              data.push_back(1'($urandom));
        end
        exp_crc = ref_crc(data);
        stream = data;
        if (m) begin
            for (int i = 0; i < 32; i++) stream.push_back(exp_crc[i] ^ (i == flip));
        end
        ptr = 0; cyc = 0; post = 0; done_cyc = -1; done_cnt = 0;
        clr_cnt = 0; clr_cyc = -1; en_cnt = 0; txv_cnt = 0; bad = 0;
        done_seen = 1'b0; ok_after = 1'b0;
        budget = (n + 40) * 20 + 100;

        @(posedge clk); #1;
        start = 1'b1; mode = m; len = LW'(n); bit_valid = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0) bad++;
        while (cyc < budget && post < 3) begin
            @(posedge clk); #1;
            cyc++;
            start = spam && !done_seen;
            mode  = 1'($urandom);
            len   = LW'($urandom);
            bit_valid = !done_seen && ($urandom_range(0, 99) < pv);
            bit_in    = (bit_valid && ptr < stream.size()) ? stream[ptr] : 1'($urandom);
            tx_ready  = !done_seen && ($urandom_range(0, 99) < pr);
            if (cyc == abort_at) begin
                check_eq({tag, "_pre_abort_ready"}, {63'd0, bit_ready}, 64'd1);
                #2 rst = 1'b1;
                #1;
                check_eq({tag, "_abort_outs"}, {54'd0, all_outs()}, 64'd0);
                break;
            end
            @(negedge clk);
            acc       = bit_valid && bit_ready;
            exp_en    = acc && (ptr < n);
            exp_shift = m ? (acc && ptr >= n) : (tx_valid && tx_ready);
            if (crc_en !== exp_en) bad++;
            if (crc_shift !== exp_shift) bad++;
            if (crc_data !== (crc_en ? bit_in : 1'b0)) bad++;
            if (!tx_valid && tx_bit) bad++;
            if (m && tx_valid) bad++;
            if (!m && ptr >= n && bit_ready) bad++;
            if ((crc_clr && (crc_en || crc_shift)) || (crc_en && crc_shift)) bad++;
            if (busy !== (!done_seen)) bad++;
            if (cyc >= 2 && !done_seen && !done && crc_ok) bad++;
            if (crc_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (crc_en) en_cnt++;
            if (tx_valid) txv_cnt++;
            if (tx_valid && tx_ready) got_tx.push_back(tx_bit);
            if (acc) ptr++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (done_seen) begin post++; ok_after = crc_ok; end
            if (done) done_seen = 1'b1;
        end
        start = 1'b0; bit_valid = 1'b0; tx_ready = 1'b0;

        if (abort_at >= 0) begin
            check_eq({tag, "_abort_accepted"}, 64'(ptr), 64'(abort_at - 2));
            @(negedge clk);
            check_eq({tag, "_abort_nodone"}, {62'd0, done, busy}, 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end

        check_eq({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_strobe_anomalies"}, 64'(bad), 64'd0);
        check_eq({tag, "_clr"}, {32'(clr_cnt), 32'(clr_cyc)}, {32'd1, 32'd1});
        check_eq({tag, "_en_count"}, 64'(en_cnt), 64'(n));
        check_eq({tag, "_crc_ok"}, {63'd0, ok_after}, {63'd0, (m ? (flip < 0) : 1'b1)});
        if (exp_lat >= 0) check_eq({tag, "_latency"}, 64'(done_cyc), 64'(exp_lat));
        if (m) begin
            check_eq({tag, "_consumed"}, 64'(ptr), 64'(stream.size()));
        end else begin
            got_word = 32'h0;
            foreach (got_tx[i]) if (i < 32) got_word[i] = got_tx[i];
            check_eq({tag, "_tx_bits"}, {32'(got_tx.size()), got_word}, {32'd32, exp_crc});
            if (pr >= 100) check_eq({tag, "_txv_cycles"}, 64'(txv_cnt), 64'd32);
        end
    endtask

    initial begin
        bit m;
        int n, pv, pr, flip;
        rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
        bit_in = 1'b0; bit_valid = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", {54'd0, all_outs()}, 64'd0);
        rst = 1'b0;

        run_frame("gen8_zero",   1'b0, 8,  32'h00, -1, 100, 100, 1'b0, 42, -1);
        run_frame("chk8_a5",     1'b1, 8,  32'hA5, -1, 100, 100, 1'b0, 42, -1);
        run_frame("chk8_a5_bad", 1'b1, 8,  32'hA5, 17, 100, 100, 1'b0, 42, -1);
        run_frame("gen0",        1'b0, 0,  -1,     -1, 100, 100, 1'b0, 34, -1);
        run_frame("gen16_stall", 1'b0, 16, -1,     -1, 50,  50,  1'b0, -1, -1);
        run_frame("chk16_stall", 1'b1, 16, -1,     -1, 50,  50,  1'b0, -1, -1);
        run_frame("gen12_spam",  1'b0, 12, -1,     -1, 100, 100, 1'b1, 46, -1);
        run_frame("abort",       1'b0, 8,  -1,     -1, 100, 100, 1'b0, -1, 6);
        run_frame("gen4_after",  1'b0, 4,  -1,     -1, 100, 100, 1'b0, 38, -1);
        for (int k = 0; k < 6; k++) begin
            m    = 1'($urandom);
            n    = $urandom_range(1, 40);
            pv   = $urandom_range(30, 100);
            pr   = $urandom_range(30, 100);
            flip = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) : -1;
            run_frame($sformatf("rand%0d", k), m, n, -1, flip, pv, pr, 1'b0, -1, -1);
        end
        run_frame("gen_maxlen", 1'b0, (1 << LW) - 1, -1, -1, 100, 100, 1'b0, (1 << LW) - 1 + 34, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adbg_crc_ctrl.md
ADBG_CRC_CTRL -- requirements
Module: adbg_crc_ctrl

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16, the width of the payload bit count.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, frame request, sampled only in IDLE.
REQ-005 SHALL have port mode, input, 1, 0 = generate (append CRC), 1 = check (compare received CRC), latched with start.
REQ-006 SHALL have port len, input, LEN_WIDTH, payload bit count, latched with start.
REQ-007 SHALL have ports bit_in / bit_valid (input, 1) and bit_ready (output, 1), the inbound serial-bit handshake.
REQ-008 SHALL have ports tx_bit / tx_valid (output, 1) and tx_ready (input, 1), the outbound CRC-bit handshake.
REQ-009 SHALL have ports busy, done, crc_ok, each an output of width 1: frame in progress, one-cycle completion pulse, and result.
REQ-010 SHALL have ports crc_clr, crc_en, crc_data, crc_shift (outputs, 1) and crc_serial (input, 1) driving and observing the external CRC32 engine (clear, LSB-first update, shift-right, bit 0 of the CRC register).

Function
REQ-011 SHALL implement states IDLE, CLEAR, DATA, CRC, DONE.
REQ-012 IDLE: busy=0; start=1 latches mode and len and moves to CLEAR; start in any other state SHALL be ignored.
REQ-013 CLEAR: crc_clr=1 for exactly one cycle; bit counter loads len; next state DATA if len!=0, else CRC with counter=32.
REQ-014 DATA: bit_ready=1; on bit_valid&bit_ready, crc_en=1 and crc_data=bit_in in the same cycle, and the counter decrements.
REQ-015 DATA SHALL exit to CRC with counter=32 on the accepted bit that takes the counter from 1 to 0.
REQ-016 CRC, generate mode: tx_valid=1 and tx_bit=crc_serial; on tx_ready, crc_shift=1 and the counter decrements; bit_ready=0.
REQ-017 CRC, check mode: bit_ready=1, tx_valid=0; on bit_valid, crc_shift=1, counter decrements, and a sticky mismatch flag sets if bit_in!=crc_serial.
REQ-018 CRC SHALL exit to DONE on the 32nd accepted or transmitted bit.
REQ-019 DONE: done=1 for one cycle; crc_ok is updated to (generate mode ? 1 : !mismatch) and held until the next CLEAR; next state IDLE.
REQ-020 crc_ok SHALL be cleared to 0 in CLEAR; mismatch SHALL be cleared in CLEAR.
REQ-021 crc_en and crc_shift SHALL never assert together; crc_clr SHALL never assert together with either.
REQ-022 crc_clr, crc_en, crc_shift, crc_data, bit_ready, tx_valid and tx_bit SHALL be combinational from state and handshake inputs; tx_bit and crc_data SHALL be 0 when their strobes are inactive.
REQ-023 busy SHALL be 1 in CLEAR, DATA, CRC and DONE.
REQ-024 With continuous handshakes, frame latency from the start cycle to the done cycle SHALL be len+34 cycles.
REQ-025 Stalls (bit_valid=0 or tx_ready=0) SHALL hold state and counter with no CRC strobes.
REQ-026 len=2^LEN_WIDTH-1 SHALL complete without counter wrap.

Reset
REQ-027 rst=1 SHALL force IDLE, counter=0, mismatch=0, crc_ok=0, done=0, busy=0, and all strobe/handshake outputs to 0, immediately and regardless of state.
REQ-028 Reset mid-frame SHALL abandon the frame without a done pulse; the next start after release SHALL behave as from power-up.

Verification
REQ-029 Generate, len=8, bits 0x00 LSB-first, tx_ready=1 -> crc_clr at cycle 1, crc_en for 8 cycles, 32 tx_valid cycles with tx_bit = model CRC bits, done at cycle 42, crc_ok=1.
REQ-030 Check, len=8, bits 0xA5 followed by the 32 model CRC bits -> crc_ok=1; repeat with received CRC bit 17 inverted -> crc_ok=0.
REQ-031 len=0, generate -> CLEAR straight to CRC; 32 shifts of 0xFFFFFFFF (tx_bit=1 each); done at cycle 34.
REQ-032 Backpressure: toggle bit_valid and tx_ready pseudo-randomly on a len=16 frame -> same CRC bits as the unstalled run; strobes only on handshake cycles.
REQ-033 Assert start at every cycle of a busy frame -> frame unaffected; one done pulse only.
REQ-034 Assert rst at the 5th DATA cycle -> all outputs 0 in the same cycle, no done; a new len=4 frame completes in 38 cycles.
